// File: rtl/slave_bus_pkg.sv
// Shared widths, default error read data and the read-return tag carried
// through the splitter's fixed-latency pipe.
package slave_bus_pkg;

  localparam int unsigned DWORD_W   = 32;
  localparam int unsigned TAG_SEL_W = 4;

  localparam logic [DWORD_W-1:0] DEF_ERR_RDATA = 32'hDEADC0DE;

  typedef struct packed {
    logic                 valid;
    logic                 err;
    logic [TAG_SEL_W-1:0] sel;
  } rd_tag_t;

endpackage : slave_bus_pkg

// File: rtl/slave_bus_rd_pipe.sv
// Fixed-latency read return: delays the read tag to line up with the channel
// read data, then selects and registers the return word.
module slave_bus_rd_pipe
  import slave_bus_pkg::*;
#(
  parameter int unsigned        C_CHANNELS   = 4,
  parameter int unsigned        C_RD_LATENCY = 2,
  parameter logic [DWORD_W-1:0] C_ERR_RDATA  = DEF_ERR_RDATA
) (
  input  logic                          clk,
  input  logic                          rst,
  input  rd_tag_t                       tag_in,
  input  logic [C_CHANNELS*DWORD_W-1:0] rdata_in,
  output logic [DWORD_W-1:0]            rdata,
  output logic                          rvalid
);

  rd_tag_t              pipe_q [C_RD_LATENCY];
  rd_tag_t              tail_c;
  logic [DWORD_W-1:0]   sel_data_c;

  // Tag shift register; a reset flushes every in-flight read.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < C_RD_LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= tag_in;
      for (int unsigned i = 1; i < C_RD_LATENCY; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign tail_c = pipe_q[C_RD_LATENCY-1];

  // Loop compare keeps out-of-range selects from indexing past the bus.
  always_comb begin
    sel_data_c = C_ERR_RDATA;
    if (!tail_c.err) begin
      for (int unsigned i = 0; i < C_CHANNELS; i++) begin
        if (TAG_SEL_W'(i) == tail_c.sel) begin
          sel_data_c = rdata_in[i*DWORD_W +: DWORD_W];
        end
      end
    end
  end

  // Return data holds its last value between valid strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= tail_c.valid;
      if (tail_c.valid) begin
        rdata <= sel_data_c;
      end
    end
  end

endmodule : slave_bus_rd_pipe

// File: rtl/slave_bus_splitter.sv
// Splits one upstream slave bus across C_CHANNELS downstream channels with a
// registered request stage, in-order fixed-latency reads and decode-error status.
module slave_bus_splitter
  import slave_bus_pkg::*;
#(
  parameter int unsigned        C_CHANNELS     = 4,
  parameter int unsigned        C_ADDR_BITS    = 16,
  parameter int unsigned        C_CH_ADDR_BITS = 12,
  parameter int unsigned        C_RD_LATENCY   = 2,
  parameter logic [DWORD_W-1:0] C_ERR_RDATA    = DEF_ERR_RDATA
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          S_WE,
  input  logic [C_ADDR_BITS-1:0]        S_WADDR,
  input  logic [DWORD_W-1:0]            S_WDATA,
  input  logic                          S_RE,
  input  logic [C_ADDR_BITS-1:0]        S_RADDR,
  output logic [DWORD_W-1:0]            S_RDATA,
  output logic                          S_RVALID,
  output logic [C_CHANNELS-1:0]         M_WE,
  output logic [C_CH_ADDR_BITS-1:0]     M_WADDR,
  output logic [DWORD_W-1:0]            M_WDATA,
  output logic [C_CHANNELS-1:0]         M_RE,
  output logic [C_CH_ADDR_BITS-1:0]     M_RADDR,
  input  logic [C_CHANNELS*DWORD_W-1:0] M_RDATA,
  input  logic                          ERR_CLR,
  output logic [15:0]                   ERR_COUNT,
  output logic                          ERR_VALID,
  output logic [C_ADDR_BITS-1:0]        ERR_ADDR
);

  localparam int unsigned SEL_W     = C_ADDR_BITS - C_CH_ADDR_BITS;
  localparam int unsigned ERR_CNT_W = 16;
  localparam int unsigned CNT_SUM_W = ERR_CNT_W + 1;

  logic [SEL_W-1:0]      wsel_c;
  logic [SEL_W-1:0]      rsel_c;
  logic                  wr_err_c;
  logic                  rd_err_c;
  logic                  any_err_c;
  logic                  capture_c;
  logic [C_CHANNELS-1:0] we_c;
  logic [C_CHANNELS-1:0] re_c;
  logic [CNT_SUM_W-1:0]  cnt_base_c;
  logic [CNT_SUM_W-1:0]  cnt_sum_c;
  logic [ERR_CNT_W-1:0]  cnt_next_c;
  rd_tag_t               rd_tag_q;

  // Address decode; selects beyond the last channel produce no strobe.
  always_comb begin
    wsel_c   = S_WADDR[C_ADDR_BITS-1:C_CH_ADDR_BITS];
    rsel_c   = S_RADDR[C_ADDR_BITS-1:C_CH_ADDR_BITS];
    wr_err_c = S_WE && (32'(wsel_c) >= C_CHANNELS);
    rd_err_c = S_RE && (32'(rsel_c) >= C_CHANNELS);
    we_c     = '0;
    re_c     = '0;
    for (int unsigned i = 0; i < C_CHANNELS; i++) begin
      we_c[i] = S_WE && (32'(wsel_c) == i);
      re_c[i] = S_RE && (32'(rsel_c) == i);
    end
  end

  // Request stage; the read tag enters the return pipe alongside M_RE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      M_WE     <= '0;
      M_RE     <= '0;
      M_WADDR  <= '0;
      M_WDATA  <= '0;
      M_RADDR  <= '0;
      rd_tag_q <= '0;
    end else begin
      M_WE     <= we_c;
      M_RE     <= re_c;
      if (S_WE) begin
        M_WADDR <= S_WADDR[C_CH_ADDR_BITS-1:0];
        M_WDATA <= S_WDATA;
      end
      if (S_RE) begin
        M_RADDR <= S_RADDR[C_CH_ADDR_BITS-1:0];
      end
      rd_tag_q <= '{valid: S_RE, err: rd_err_c, sel: TAG_SEL_W'(rsel_c)};
    end
  end

  // A clear in the same cycle as an error restarts counting from that error.
  always_comb begin
    any_err_c  = wr_err_c | rd_err_c;
    capture_c  = any_err_c && (ERR_CLR || !ERR_VALID);
    cnt_base_c = ERR_CLR ? CNT_SUM_W'(0) : CNT_SUM_W'(ERR_COUNT);
    cnt_sum_c  = cnt_base_c + CNT_SUM_W'(wr_err_c) + CNT_SUM_W'(rd_err_c);
    cnt_next_c = cnt_sum_c[ERR_CNT_W] ? '1 : cnt_sum_c[ERR_CNT_W-1:0];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ERR_COUNT <= '0;
      ERR_VALID <= 1'b0;
      ERR_ADDR  <= '0;
    end else begin
      ERR_COUNT <= cnt_next_c;
      if (capture_c) begin
        ERR_VALID <= 1'b1;
        ERR_ADDR  <= wr_err_c ? S_WADDR : S_RADDR;
      end else if (ERR_CLR) begin
        ERR_VALID <= 1'b0;
      end
    end
  end

  slave_bus_rd_pipe #(
    .C_CHANNELS   (C_CHANNELS),
    .C_RD_LATENCY (C_RD_LATENCY),
    .C_ERR_RDATA  (C_ERR_RDATA)
  ) u_rd_pipe (
    .clk      (CLK),
    .rst      (RST),
    .tag_in   (rd_tag_q),
    .rdata_in (M_RDATA),
    .rdata    (S_RDATA),
    .rvalid   (S_RVALID)
  );

endmodule : slave_bus_splitter

// File: tb/tb_slave_bus_splitter.sv
// Bench for slave_bus_splitter: three-channel memory model with fixed read
// latency, scoreboard of expected read returns and per-feature directed tasks.
`timescale 1ns/1ps
module tb_slave_bus_splitter;

  localparam int unsigned CH  = 3;
  localparam int unsigned AW  = 16;
  localparam int unsigned CAW = 12;
  localparam int unsigned LAT = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            s_we = 1'b0;
  logic [AW-1:0]   s_waddr = '0;
  logic [31:0]     s_wdata = '0;
  logic            s_re = 1'b0;
  logic [AW-1:0]   s_raddr = '0;
  logic [31:0]     s_rdata;
  logic            s_rvalid;
  logic [CH-1:0]   m_we;
  logic [CAW-1:0]  m_waddr;
  logic [31:0]     m_wdata;
  logic [CH-1:0]   m_re;
  logic [CAW-1:0]  m_raddr;
  logic [CH*32-1:0] m_rdata;
  logic            err_clr = 1'b0;
  logic [15:0]     err_count;
  logic            err_valid;
  logic [AW-1:0]   err_addr;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q [$];
  logic [31:0] exp_d;

  always #5 clk = ~clk;

  slave_bus_splitter #(
    .C_CHANNELS     (CH),
    .C_ADDR_BITS    (AW),
    .C_CH_ADDR_BITS (CAW),
    .C_RD_LATENCY   (LAT),
    .C_ERR_RDATA    (32'hDEADC0DE)
  ) dut (
    .CLK (clk), .RST (rst),
    .S_WE (s_we), .S_WADDR (s_waddr), .S_WDATA (s_wdata),
    .S_RE (s_re), .S_RADDR (s_raddr),
    .S_RDATA (s_rdata), .S_RVALID (s_rvalid),
    .M_WE (m_we), .M_WADDR (m_waddr), .M_WDATA (m_wdata),
    .M_RE (m_re), .M_RADDR (m_raddr), .M_RDATA (m_rdata),
    .ERR_CLR (err_clr), .ERR_COUNT (err_count),
    .ERR_VALID (err_valid), .ERR_ADDR (err_addr)
  );

  // Downstream channel memories: data appears LAT cycles after M_RE.
  logic [CH-1:0]  mre_d   [LAT];
  logic [CAW-1:0] maddr_d [LAT];
  logic [31:0]    mem     [CH][4096];

  always @(posedge clk) begin
    mre_d[0]   <= m_re;
    maddr_d[0] <= m_raddr;
    for (int i = 1; i < LAT; i++) begin
      mre_d[i]   <= mre_d[i-1];
      maddr_d[i] <= maddr_d[i-1];
    end
    for (int c = 0; c < CH; c++) begin
      if (m_we[c]) mem[c][m_waddr] <= m_wdata;
    end
  end

  always_comb begin
    m_rdata = '0;
    for (int c = 0; c < CH; c++) begin
      if (mre_d[LAT-1][c]) m_rdata[c*32 +: 32] = mem[c][maddr_d[LAT-1]];
    end
  end

  // Scoreboard: every returned read must match the oldest expected word.
  always @(posedge clk) begin
    #1;
    if (s_rvalid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rdata_unexpected: got %h with no read outstanding", s_rdata);
      end else begin
        exp_d = exp_q.pop_front();
        if (s_rdata !== exp_d) begin
          errors++;
          $display("FAIL rdata_order: got %h expected %h", s_rdata, exp_d);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s_we = 1'b0;
    s_re = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({m_we, m_re, s_rvalid, err_valid} !== '0) begin
      errors++;
      $display("FAIL reset_strobes: got %b expected 0", {m_we, m_re, s_rvalid, err_valid});
    end
    checks++;
    if ({s_rdata, m_wdata, m_waddr, m_raddr, err_count, err_addr} !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0", {s_rdata, m_wdata, m_waddr, m_raddr, err_count, err_addr});
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_write();
    logic [AW-1:0] wa [5] = '{16'h1004, 16'h2008, 16'h0000, 16'h1000, 16'h2000};
    logic [31:0]   wd [5] = '{32'hA5A50001, 32'h12345678, 32'h0, 32'h1, 32'h2};
    logic [CH-1:0] oh [5] = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    for (int i = 0; i < 5; i++) begin
      s_we = 1'b1; s_waddr = wa[i]; s_wdata = wd[i];
      step();
      checks++;
      if (m_we !== oh[i] || m_waddr !== wa[i][CAW-1:0] || m_wdata !== wd[i]) begin
        errors++;
        $display("FAIL write_%0d: got we=%b addr=%h data=%h expected we=%b addr=%h data=%h",
                 i, m_we, m_waddr, m_wdata, oh[i], wa[i][CAW-1:0], wd[i]);
      end
    end
    idle();
    step();
    checks++;
    if (m_we !== '0 || err_count !== 16'd0 || err_valid !== 1'b0) begin
      errors++;
      $display("FAIL write_idle: got we=%b cnt=%0d ev=%b expected 0", m_we, err_count, err_valid);
    end
  endtask

  task automatic test_read();
    s_re = 1'b1; s_raddr = 16'h2008;
    exp_q.push_back(32'h12345678);
    step();
    checks++;
    if (m_re !== 3'b100 || m_raddr !== 12'h008) begin
      errors++;
      $display("FAIL read_req: got re=%b addr=%h expected re=100 addr=008", m_re, m_raddr);
    end
    idle();
    step();
    step();
    checks++;
    if (s_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL read_early: got rvalid=%b expected 0 at N+3", s_rvalid);
    end
    step();
    checks++;
    if (s_rvalid !== 1'b1) begin
      errors++;
      $display("FAIL read_latency: got rvalid=%b expected 1 at N+4", s_rvalid);
    end
    step();
    checks++;
    if (s_rvalid !== 1'b0 || s_rdata !== 32'h12345678) begin
      errors++;
      $display("FAIL read_hold: got rvalid=%b data=%h expected 0/12345678", s_rvalid, s_rdata);
    end
  endtask

  task automatic test_err_read();
    s_re = 1'b1; s_raddr = 16'h3000;
    exp_q.push_back(32'hDEADC0DE);
    step();
    checks++;
    if (m_re !== '0 || err_count !== 16'd1 || err_valid !== 1'b1 || err_addr !== 16'h3000) begin
      errors++;
      $display("FAIL err_read_status: got re=%b cnt=%0d ev=%b ea=%h expected 000/1/1/3000",
               m_re, err_count, err_valid, err_addr);
    end
    idle();
    step();
    step();
    step();
    checks++;
    if (s_rvalid !== 1'b1) begin
      errors++;
      $display("FAIL err_read_latency: got rvalid=%b expected 1 at N+4", s_rvalid);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [CH-1:0] oh [3] = '{3'b001, 3'b010, 3'b100};
    for (int i = 0; i < 3; i++) begin
      s_re = 1'b1; s_raddr = AW'(i * 16'h1000);
      exp_q.push_back(32'(i));
      step();
      checks++;
      if (m_re !== oh[i]) begin
        errors++;
        $display("FAIL b2b_req_%0d: got re=%b expected %b", i, m_re, oh[i]);
      end
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (s_rvalid !== (i < 3)) begin
        errors++;
        $display("FAIL b2b_valid_%0d: got rvalid=%b expected %b", i, s_rvalid, (i < 3));
      end
    end
  endtask

  task automatic test_simultaneous();
    s_we = 1'b1; s_waddr = 16'h1010; s_wdata = 32'hCAFE0010;
    s_re = 1'b1; s_raddr = 16'h1000;
    exp_q.push_back(32'h1);
    step();
    checks++;
    if (m_we !== 3'b010 || m_re !== 3'b010 || m_waddr !== 12'h010 || m_raddr !== 12'h000) begin
      errors++;
      $display("FAIL simul_req: got we=%b re=%b wa=%h ra=%h expected 010/010/010/000",
               m_we, m_re, m_waddr, m_raddr);
    end
    idle();
    repeat (4) step();
  endtask

  task automatic test_err_clr();
    for (int i = 0; i < 4; i++) begin
      s_we = 1'b1; s_waddr = 16'hF000 | AW'(i);
      step();
    end
    idle();
    step();
    checks++;
    if (err_count !== 16'd5 || err_addr !== 16'h3000) begin
      errors++;
      $display("FAIL err_accum: got cnt=%0d ea=%h expected 5/3000", err_count, err_addr);
    end
    s_we = 1'b1; s_waddr = 16'h3010;
    s_re = 1'b1; s_raddr = 16'h4000;
    err_clr = 1'b1;
    exp_q.push_back(32'hDEADC0DE);
    step();
    checks++;
    if (err_count !== 16'd2 || err_addr !== 16'h3010 || err_valid !== 1'b1 || m_we !== '0 || m_re !== '0) begin
      errors++;
      $display("FAIL err_clr_collide: got cnt=%0d ea=%h ev=%b we=%b re=%b expected 2/3010/1/000/000",
               err_count, err_addr, err_valid, m_we, m_re);
    end
    idle();
    err_clr = 1'b1;
    step();
    checks++;
    if (err_count !== 16'd0 || err_valid !== 1'b0) begin
      errors++;
      $display("FAIL err_clr: got cnt=%0d ev=%b expected 0/0", err_count, err_valid);
    end
    idle();
    repeat (4) step();
  endtask

  task automatic test_saturation();
    s_we = 1'b1; s_waddr = 16'h3000;
    s_re = 1'b1; s_raddr = 16'h3004;
    for (int i = 0; i < 32767; i++) begin
      exp_q.push_back(32'hDEADC0DE);
      step();
    end
    checks++;
    if (err_count !== 16'hFFFE || err_addr !== 16'h3000) begin
      errors++;
      $display("FAIL sat_pre: got cnt=%h ea=%h expected FFFE/3000", err_count, err_addr);
    end
    exp_q.push_back(32'hDEADC0DE);
    step();
    checks++;
    if (err_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_cap: got cnt=%h expected FFFF", err_count);
    end
    s_re = 1'b0;
    step();
    checks++;
    if (err_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_hold: got cnt=%h expected FFFF", err_count);
    end
    idle();
    err_clr = 1'b1;
    step();
    idle();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    step();
    checks++;
    if (exp_q.size() != 0 || err_count !== 16'd0) begin
      errors++;
      $display("FAIL sat_drain: got pending=%0d cnt=%0d expected 0/0", exp_q.size(), err_count);
    end
  endtask

  task automatic test_reset_mid();
    s_re = 1'b1; s_raddr = 16'h1000;
    exp_q.push_back(32'h1);
    step();
    s_re = 1'b0;
    s_we = 1'b1; s_waddr = 16'h3000; s_wdata = 32'h5555AAAA;
    step();
    idle();
    rst = 1'b1;
    exp_q.delete();
    step();
    checks++;
    if ({m_we, m_re, s_rvalid, err_valid} !== '0 ||
        {s_rdata, m_wdata, m_waddr, m_raddr, err_count, err_addr} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got we=%b re=%b rv=%b ev=%b rd=%h wd=%h cnt=%0d ea=%h expected all 0",
               m_we, m_re, s_rvalid, err_valid, s_rdata, m_wdata, err_count, err_addr);
    end
    rst = 1'b0;
    step();
    checks++;
    if (s_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_flush: got rvalid=%b expected 0 at N+4", s_rvalid);
    end
    repeat (3) step();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_err_read();
    test_back_to_back();
    test_simultaneous();
    test_err_clr();
    test_saturation();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_drain: got pending=%0d expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_slave_bus_splitter

// File: doc/slave_bus_splitter.md
Name: slave_bus_splitter

Overview:
- Parametrised successor to the single-slave virtual bus hookup in the top level.
- Takes one upstream slave bus (write/read strobes, address, 32-bit data) driven by the virtual slave BFM.
- Decodes the address into C_CHANNELS downstream slave-bus channels, each a dut-side register/memory block.
- Adds what the old point-to-point hookup lacks:
  - registered request stage;
  - fixed-latency, in-order read return with a valid strobe;
  - out-of-range decode error reporting.

Parameters:
- C_CHANNELS, 4: number of downstream channels (1..16).
- C_ADDR_BITS, 16: upstream dword address width.
- C_CH_ADDR_BITS, 12: per-channel address width. Must satisfy C_ADDR_BITS > C_CH_ADDR_BITS.
- C_RD_LATENCY, 2: cycles from M_RE to valid M_RDATA at the downstream channel (1..8).
- C_ERR_RDATA, 32'hDEADC0DE: read data returned for decode-error reads.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous reset, active-high.
- S_WE  in  1  upstream write strobe.
- S_WADDR  in  C_ADDR_BITS  upstream write address.
- S_WDATA  in  32  upstream write data.
- S_RE  in  1  upstream read strobe.
- S_RADDR  in  C_ADDR_BITS  upstream read address.
- S_RDATA  out  32  read return data.
- S_RVALID  out  1  read return valid.
- M_WE  out  C_CHANNELS  one-hot per-channel write strobe.
- M_WADDR  out  C_CH_ADDR_BITS  shared channel write address.
- M_WDATA  out  32  shared write data.
- M_RE  out  C_CHANNELS  one-hot per-channel read strobe.
- M_RADDR  out  C_CH_ADDR_BITS  shared channel read address.
- M_RDATA  in  C_CHANNELS*32  per-channel read data; channel i occupies bits [32*i+31:32*i].
- ERR_CLR  in  1  clears error status.
- ERR_COUNT  out  16  saturating decode-error count.
- ERR_VALID  out  1  ERR_ADDR holds a captured address.
- ERR_ADDR  out  C_ADDR_BITS  first erroneous address since last clear.

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous and active-high.
- Reset values: all outputs 0. M_WE, M_RE, S_RVALID, ERR_* are 0; data and address outputs are 0.
- Decode:
  - sel = addr[C_ADDR_BITS-1:C_CH_ADDR_BITS]; offset = addr[C_CH_ADDR_BITS-1:0].
  - A request with sel >= C_CHANNELS is a decode error.
- Write path: S_WE in cycle N drives M_WE[sel]=1 in cycle N+1, with M_WADDR=offset and M_WDATA registered.
  - An error write produces no M_WE.
  - Writes are posted; no response.
- Read path, S_RE in cycle N:
  - M_RE[sel]=1 and M_RADDR=offset in N+1.
  - A tag {valid, err, sel} enters a C_RD_LATENCY-deep shift pipe.
  - The tag exits at N+1+C_RD_LATENCY. That cycle, M_RDATA[sel] is captured, or C_ERR_RDATA if err.
  - S_RDATA is registered and S_RVALID=1 in cycle N+C_RD_LATENCY+2.
  - An error read issues no M_RE but keeps the same latency, so ordering is preserved.
- Throughput: one read and one write per cycle. Back-to-back reads return on consecutive cycles, in issue order.
- S_RDATA holds its last value while S_RVALID=0.
- Simultaneous S_WE and S_RE: both are forwarded independently, even to the same channel and offset. Ordering is the downstream's responsibility.
- Error status:
  - Each erroneous request increments ERR_COUNT, saturating at 16'hFFFF.
  - A write error and a read error in the same cycle add 2, saturated.
  - ERR_ADDR/ERR_VALID are captured only when ERR_VALID=0. If both error in the same cycle, the write address wins.
- ERR_CLR: clears ERR_COUNT and ERR_VALID next cycle. If an error occurs in the same cycle as ERR_CLR, the error wins: count restarts at 1 (or 2) and the address is captured.
- Reset mid-operation: pipe tags are flushed, in-flight reads produce no S_RVALID, and error status is cleared.

Decomposition:
- Package slave_bus_pkg:
  - DWORD_W=32;
  - default C_ERR_RDATA;
  - rd_tag_t struct {logic valid; logic err; logic [3:0] sel}.
- Sub-module slave_bus_rd_pipe: parametrised-depth tag shift register plus output data mux/register.
- The top splitter holds decode, request registers and error logic.

Test Plan (C_CHANNELS=3, C_ADDR_BITS=16, C_CH_ADDR_BITS=12, C_RD_LATENCY=2):
1. Write 0x1004, data 0xA5A50001 at cycle N -> at N+1: M_WE=3'b010, M_WADDR=0x004, M_WDATA=0xA5A50001; no error.
2. Read 0x2008 at N, ch2 model returns 0x12345678 -> M_RE=3'b100 and M_RADDR=0x008 at N+1; S_RVALID=1 and S_RDATA=0x12345678 at N+4.
3. Read 0x3000 at N -> M_RE stays 0; at N+4 S_RDATA=0xDEADC0DE; ERR_COUNT=1, ERR_VALID=1, ERR_ADDR=0x3000.
4. Reads 0x0000, 0x1000, 0x2000 on N, N+1, N+2 (models return 0x0, 0x1, 0x2) -> S_RVALID high N+4..N+6 with data 0x0, 0x1, 0x2 in order.
5. Error write 0x3010 and error read 0x4000 in the same cycle as ERR_CLR, with prior count 5 -> ERR_COUNT=2, ERR_ADDR=0x3010.
6. Read 0x1000 at N, RST=1 at N+2 -> no S_RVALID at N+4; all outputs 0 from N+3.
